sm4_key_schedule: RTL and testbench

SM4_KEY_SCHEDULE -- requirements
Module: sm4_key_schedule

---
 rtl/sm4_key_schedule.sv | 162 ++++++++++++++++
 tb/tb_sm4_key_schedule.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/sm4_key_schedule.sv
// sm4_key_schedule: SM4 round-key expansion with on-chip storage of all 32
// round keys and a registered read port usable in either round order.
//
// Ports:
//   clk        - clock, all state updates on the rising edge
//   rst_n      - asynchronous active-low reset
//   key_start  - one-cycle request to expand key_in (ignored while expanding)
//   key_in     - 128-bit master key, MK0 = key_in[127:96] .. MK3 = key_in[31:0]
//   decrypt    - read order: 0 = rk[rk_index], 1 = rk[31 - rk_index]
//   rk_index   - round number requested by the round datapath
//   rk_out     - selected round key, one cycle after rk_index/decrypt, 0 unless ready
//   key_busy   - expansion in progress
//   key_ready  - all 32 round keys valid
//
// transform_for_key_exp: key-schedule transform T' = L'(tau(x)), i.e. a
// byte-wise S-box followed by B ^ (B <<< 13) ^ (B <<< 23).
//
// Ports:
//   din        - 32-bit transform input
//   dout       - 32-bit transform output

module transform_for_key_exp (
  input  logic [31:0] din,
  output logic [31:0] dout
);

  localparam logic [7:0] SBOX [256] = '{
    8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
    8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
    8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
    8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
    8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
    8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
    8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
    8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
    8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
    8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
    8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
    8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
    8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
    8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
  };

  logic [31:0] b;

  always_comb begin
    b = '0;
    for (int unsigned j = 0; j < 4; j++) begin
      b[j*8 +: 8] = SBOX[din[j*8 +: 8]];
    end
  end

  // B ^ (B <<< 13) ^ (B <<< 23)
  assign dout = b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};

endmodule

module sm4_key_schedule (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_start,
  input  logic [127:0] key_in,
  input  logic         decrypt,
  input  logic [4:0]   rk_index,
  output logic [31:0]  rk_out,
  output logic         key_busy,
  output logic         key_ready
);

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    READY
  } state_t;

  localparam logic [127:0] FK = 128'hA3B1BAC6_56AA3350_677D9197_B27022DC;

  state_t      state;
  logic [4:0]  cnt;
  logic [31:0] k  [4];
  logic [31:0] rk [32];

  logic [7:0]  ck_base;
  logic [31:0] ck;
  logic [31:0] t_in;
  logic [31:0] t_out;
  logic [31:0] new_k;
  logic [4:0]  sel_idx;

  // CK byte j of round i is (28*i + 7*j) mod 256; 8-bit arithmetic wraps for free.
  assign ck_base = {3'b000, cnt} * 8'd28;
  assign ck      = {ck_base, ck_base + 8'd7, ck_base + 8'd14, ck_base + 8'd21};

  assign t_in  = k[1] ^ k[2] ^ k[3] ^ ck;
  assign new_k = k[0] ^ t_out;

  transform_for_key_exp u_tprime (
    .din  (t_in),
    .dout (t_out)
  );

  // 31 - rk_index is the bitwise complement for a 5-bit index.
  assign sel_idx = decrypt ? ~rk_index : rk_index;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      rk_out    <= '0;
      key_busy  <= 1'b0;
      key_ready <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) begin
        k[i] <= '0;
      end
      for (int unsigned i = 0; i < 32; i++) begin
        rk[i] <= '0;
      end
    end else begin
      rk_out <= key_ready ? rk[sel_idx] : '0;

      case (state)
        IDLE, READY: begin
          if (key_start) begin
            k[0]      <= key_in[127:96] ^ FK[127:96];
            k[1]      <= key_in[95:64]  ^ FK[95:64];
            k[2]      <= key_in[63:32]  ^ FK[63:32];
            k[3]      <= key_in[31:0]   ^ FK[31:0];
            cnt       <= '0;
            state     <= EXPAND;
            key_busy  <= 1'b1;
            key_ready <= 1'b0;
          end
        end

        EXPAND: begin
          rk[cnt] <= new_k;
          k[0]    <= k[1];
          k[1]    <= k[2];
          k[2]    <= k[3];
          k[3]    <= new_k;
          if (cnt == 5'd31) begin
            // Counter holds at 31; leaving EXPAND stops all further writes.
            state     <= READY;
            key_busy  <= 1'b0;
            key_ready <= 1'b1;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end

        default: begin
          state     <= IDLE;
          key_busy  <= 1'b0;
          key_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sm4_key_schedule.sv
// Directed and model-based bench for sm4_key_schedule.
module tb_sm4_key_schedule;

  logic         clk;
  logic         rst_n;
  logic         key_start;
  logic [127:0] key_in;
  logic         decrypt;
  logic [4:0]   rk_index;
  logic [31:0]  rk_out;
  logic         key_busy;
  logic         key_ready;

  int total = 0;
  int bad   = 0;

  sm4_key_schedule dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_start (key_start),
    .key_in    (key_in),
    .decrypt   (decrypt),
    .rk_index  (rk_index),
    .rk_out    (rk_out),
    .key_busy  (key_busy),
    .key_ready (key_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [127:0] STD_KEY = 128'h01234567_89ABCDEF_FEDCBA98_76543210;

  localparam logic [7:0] SB [256] = '{
    8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
    8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
    8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
    8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
    8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
    8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
    8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
    8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
    8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
    8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
    8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
    8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
    8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
    8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
  };

  typedef struct {
    logic        dec;
    logic [4:0]  idx;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs [6];
  logic [31:0] mrk [32];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // busy and ready must never be asserted together.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      total++;
      if (key_busy && key_ready) begin
        bad++;
        $display("FAIL busy_ready_exclusive actual=11 required=not both at %0t", $time);
      end
    end
  end

  function automatic logic [31:0] tprime(input logic [31:0] x);
    logic [31:0] s;
    s = {SB[x[31:24]], SB[x[23:16]], SB[x[15:8]], SB[x[7:0]]};
    return s ^ {s[18:0], s[31:19]} ^ {s[8:0], s[31:9]};
  endfunction

  task automatic model_expand(input logic [127:0] mk);
    logic [31:0] kk [36];
    logic [31:0] ckw;
    kk[0] = mk[127:96] ^ 32'hA3B1BAC6;
    kk[1] = mk[95:64]  ^ 32'h56AA3350;
    kk[2] = mk[63:32]  ^ 32'h677D9197;
    kk[3] = mk[31:0]   ^ 32'hB27022DC;
    for (int i = 0; i < 32; i++) begin
      for (int j = 0; j < 4; j++) ckw[31-8*j -: 8] = 8'(((4*i + j) * 7) % 256);
      kk[i+4] = kk[i] ^ tprime(kk[i+1] ^ kk[i+2] ^ kk[i+3] ^ ckw);
      mrk[i] = kk[i+4];
    end
  endtask

  // Starts an expansion at E0 and follows it for 32 edges; optional stray
  // key_start pulses before E5 and E20 must be ignored.
  task automatic run_expansion(input logic [127:0] key, input bit pulses, input string tag);
    int ready_edge;
    bit seq_err;
    ready_edge = -1;
    seq_err = 1'b0;
    @(negedge clk);
    key_in = key;
    key_start = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_e0_busy"}, {31'd0, key_busy}, 32'd1);
    check({tag, "_e0_ready"}, {31'd0, key_ready}, 32'd0);
    for (int n = 1; n <= 32; n++) begin
      @(negedge clk);
      key_start = pulses && (n == 5 || n == 20);
      key_in = pulses ? ~key : key;
      @(posedge clk);
      #1;
      if (rk_out !== 32'd0) seq_err = 1'b1;
      if (key_ready === 1'b1 && ready_edge < 0) ready_edge = n;
      if (n < 32 && key_busy !== 1'b1) seq_err = 1'b1;
    end
    @(negedge clk);
    key_start = 1'b0;
    check({tag, "_ready_edge"}, 32'(ready_edge), 32'd32);
    check({tag, "_busy_zero_during_expand"}, {31'd0, seq_err}, 32'd0);
    check({tag, "_busy_after"}, {31'd0, key_busy}, 32'd0);
  endtask

  task automatic read_key(input logic dec, input logic [4:0] idx, output logic [31:0] val);
    @(negedge clk);
    decrypt = dec;
    rk_index = idx;
    @(posedge clk);
    #1;
    val = rk_out;
  endtask

  task automatic run_table(input string tag);
    logic [31:0] v;
    for (int i = 0; i < 6; i++) begin
      read_key(vecs[i].dec, vecs[i].idx, v);
      check($sformatf("%s_vec%0d_d%0d_i%0d", tag, i, vecs[i].dec, vecs[i].idx), v, vecs[i].exp);
    end
  endtask

  initial begin
    logic [31:0] v;
    logic [127:0] rkey;
    logic d;
    logic [4:0] ix;
    bit rnd_err;

    vecs[0] = '{dec: 1'b0, idx: 5'd0,  exp: 32'hF12186F9};
    vecs[1] = '{dec: 1'b0, idx: 5'd1,  exp: 32'h41662B61};
    vecs[2] = '{dec: 1'b0, idx: 5'd31, exp: 32'h9124A012};
    vecs[3] = '{dec: 1'b1, idx: 5'd0,  exp: 32'h9124A012};
    vecs[4] = '{dec: 1'b1, idx: 5'd31, exp: 32'hF12186F9};
    vecs[5] = '{dec: 1'b1, idx: 5'd30, exp: 32'h41662B61};

    rst_n = 1'b0;
    key_start = 1'b0;
    key_in = '0;
    decrypt = 1'b0;
    rk_index = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rk_out", rk_out, 32'd0);
    check("reset_busy", {31'd0, key_busy}, 32'd0);
    check("reset_ready", {31'd0, key_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_ready", {31'd0, key_ready}, 32'd0);

    run_expansion(STD_KEY, 1'b0, "std");
    run_table("std");

    run_expansion(STD_KEY, 1'b1, "pulses");
    run_table("pulses");

    // Asynchronous reset in the middle of an expansion (just after E17).
    @(negedge clk);
    key_in = STD_KEY;
    key_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    key_start = 1'b0;
    repeat (17) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midreset_busy", {31'd0, key_busy}, 32'd0);
    check("midreset_ready", {31'd0, key_ready}, 32'd0);
    check("midreset_rk_out", rk_out, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("no_resume_busy", {31'd0, key_busy}, 32'd0);
    check("no_resume_ready", {31'd0, key_ready}, 32'd0);
    run_expansion(STD_KEY, 1'b0, "after_reset");
    run_table("after_reset");

    // Restart from READY with an all-zero master key.
    model_expand(128'd0);
    run_expansion(128'd0, 1'b0, "zero");
    for (int i = 0; i < 32; i++) begin
      read_key(1'b0, 5'(i), v);
      check($sformatf("zero_fwd_%0d", i), v, mrk[i]);
    end
    read_key(1'b1, 5'd0, v);
    check("zero_rev_0", v, mrk[31]);
    read_key(1'b1, 5'd31, v);
    check("zero_rev_31", v, mrk[0]);

    // Random master keys against the reference model.
    for (int t = 0; t < 1000; t++) begin
      rkey = {$urandom, $urandom, $urandom, $urandom};
      model_expand(rkey);
      run_expansion(rkey, 1'b0, $sformatf("rnd%0d", t));
      rnd_err = 1'b0;
      for (int r = 0; r < 3; r++) begin
        d = 1'($urandom_range(0, 1));
        ix = 5'($urandom_range(0, 31));
        read_key(d, ix, v);
        check($sformatf("rnd%0d_d%0d_i%0d", t, d, ix), v, d ? mrk[31 - int'(ix)] : mrk[ix]);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
